// File: rtl/modo_simd_interpolador.sv
// LANES-wide bilinear interpolator: 3-stage pipeline (weights, products, sum/round)
// with valid/ready backpressure, per-lane masking and a delivered-pixel counter.

module modo_simd_interpolador_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        avanzar,
  input  logic [7:0]  p00,
  input  logic [7:0]  p10,
  input  logic [7:0]  p01,
  input  logic [7:0]  p11,
  input  logic [15:0] fx,
  input  logic [15:0] fy,
  input  logic        mask,
  output logic [7:0]  pixel,
  output logic [15:0] pixel_q,
  output logic        mask_out
);
  typedef struct packed {
    logic [7:0] p00, p10, p01, p11;
    logic [8:0] wx, wxb, wy, wyb;
    logic       m;
  } s1_t;

  typedef struct packed {
    logic [23:0] a, b, c, d;
    logic        m;
  } s2_t;

  s1_t         s1;
  s2_t         s2;
  logic [23:0] acc;
  logic        unused_int;

  // integer bytes of fx/fy carry no weight information
  assign unused_int = ^{fx[15:8], fy[15:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1 <= '0;
    else if (avanzar) begin
      s1.p00 <= p00;
      s1.p10 <= p10;
      s1.p01 <= p01;
      s1.p11 <= p11;
      s1.wx  <= {1'b0, fx[7:0]};
      s1.wxb <= 9'd256 - {1'b0, fx[7:0]};
      s1.wy  <= {1'b0, fy[7:0]};
      s1.wyb <= 9'd256 - {1'b0, fy[7:0]};
      s1.m   <= mask;
    end
  end

  // each product is at most 255*65536, so 24 bits hold it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2 <= '0;
    else if (avanzar) begin
      s2.a <= {16'd0, s1.p00} * {15'd0, s1.wxb} * {15'd0, s1.wyb};
      s2.b <= {16'd0, s1.p10} * {15'd0, s1.wx}  * {15'd0, s1.wyb};
      s2.c <= {16'd0, s1.p01} * {15'd0, s1.wxb} * {15'd0, s1.wy};
      s2.d <= {16'd0, s1.p11} * {15'd0, s1.wx}  * {15'd0, s1.wy};
      s2.m <= s1.m;
    end
  end

  // weights sum to 65536, so acc and both rounded forms stay below 2^24
  assign acc = s2.a + s2.b + s2.c + s2.d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel    <= '0;
      pixel_q  <= '0;
      mask_out <= 1'b0;
    end else if (avanzar) begin
      pixel    <= s2.m ? 8'((acc + 24'd32768) >> 16) : 8'd0;
      pixel_q  <= s2.m ? 16'((acc + 24'd128) >> 8)   : 16'd0;
      mask_out <= s2.m;
    end
  end
endmodule

module modo_simd_interpolador #(
  parameter int LANES = 4,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  entrada_valida,
  output logic                  entrada_lista,
  input  logic [LANES-1:0]      mascara_entrada,
  input  logic [8*LANES-1:0]    p00_entrada,
  input  logic [8*LANES-1:0]    p10_entrada,
  input  logic [8*LANES-1:0]    p01_entrada,
  input  logic [8*LANES-1:0]    p11_entrada,
  input  logic [16*LANES-1:0]   fx_entrada,
  input  logic [16*LANES-1:0]   fy_entrada,
  output logic                  salida_valida,
  input  logic                  salida_lista,
  output logic [8*LANES-1:0]    pixel_salida,
  output logic [16*LANES-1:0]   pixel_salida_q,
  output logic [LANES-1:0]      mascara_salida,
  output logic                  ocupado,
  output logic                  listo,
  input  logic                  limpiar_contador,
  output logic [CNT_W-1:0]      contador_pixeles
);
  localparam int STAGES = 3;
  localparam int PCW    = $clog2(LANES + 1);

  logic [STAGES:1] vld_pipe;
  logic            avanzar;
  logic [PCW-1:0]  pc;

  assign avanzar        = !(vld_pipe[STAGES] && !salida_lista);
  assign entrada_lista  = avanzar;
  assign listo          = avanzar;
  assign salida_valida  = vld_pipe[STAGES];
  assign ocupado        = |vld_pipe;

  // bubbles enter S1 whenever we advance without a beat; no compression
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else if (avanzar) vld_pipe <= {vld_pipe[STAGES-1:1], entrada_valida};
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    modo_simd_interpolador_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .avanzar  (avanzar),
      .p00      (p00_entrada[8*i +: 8]),
      .p10      (p10_entrada[8*i +: 8]),
      .p01      (p01_entrada[8*i +: 8]),
      .p11      (p11_entrada[8*i +: 8]),
      .fx       (fx_entrada[16*i +: 16]),
      .fy       (fy_entrada[16*i +: 16]),
      .mask     (mascara_entrada[i]),
      .pixel    (pixel_salida[8*i +: 8]),
      .pixel_q  (pixel_salida_q[16*i +: 16]),
      .mask_out (mascara_salida[i])
    );
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) pc = pc + PCW'(mascara_salida[i]);
  end

  // clear wins over a same-edge handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) contador_pixeles <= '0;
    else if (limpiar_contador) contador_pixeles <= '0;
    else if (vld_pipe[STAGES] && salida_lista) contador_pixeles <= contador_pixeles + CNT_W'(pc);
  end
endmodule

// File: tb/tb_modo_simd_interpolador.sv
// Bench for modo_simd_interpolador: arithmetic reference model + queue scoreboard
// checked every cycle, plus hand-computed vectors for the key cases.

module tb_modo_simd_interpolador;
  localparam int LANES = 4;
  localparam int CNT_W = 4;

  logic                clk = 0, rst_n = 0;
  logic                entrada_valida = 0, entrada_lista, salida_valida, salida_lista = 1;
  logic [LANES-1:0]    mascara_entrada = '0, mascara_salida;
  logic [8*LANES-1:0]  p00 = '0, p10 = '0, p01 = '0, p11 = '0, pixel_salida;
  logic [16*LANES-1:0] fx = '0, fy = '0, pixel_salida_q;
  logic                ocupado, listo, limpiar_contador = 0;
  logic [CNT_W-1:0]    contador_pixeles;

  modo_simd_interpolador #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_lista(entrada_lista),
    .mascara_entrada(mascara_entrada), .p00_entrada(p00), .p10_entrada(p10),
    .p01_entrada(p01), .p11_entrada(p11), .fx_entrada(fx), .fy_entrada(fy),
    .salida_valida(salida_valida), .salida_lista(salida_lista), .pixel_salida(pixel_salida),
    .pixel_salida_q(pixel_salida_q), .mascara_salida(mascara_salida), .ocupado(ocupado),
    .listo(listo), .limpiar_contador(limpiar_contador), .contador_pixeles(contador_pixeles)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, delivered = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pix;
    logic [63:0] q;
    logic [3:0]  m;
  } exp_t;

  function automatic exp_t model(input logic [31:0] a, b, c, d, input logic [63:0] x, y,
                                 input logic [3:0] m);
    exp_t e;
    int wx, wy, acc;
    e.pix = '0; e.q = '0; e.m = m;
    for (int l = 0; l < 4; l++) begin
      wx  = int'(x[16*l +: 8]);
      wy  = int'(y[16*l +: 8]);
      acc = int'(a[8*l +: 8]) * (256 - wx) * (256 - wy) + int'(b[8*l +: 8]) * wx * (256 - wy)
          + int'(c[8*l +: 8]) * (256 - wx) * wy         + int'(d[8*l +: 8]) * wx * wy;
      if (m[l]) begin
        e.pix[8*l +: 8]  = 8'((acc + 32768) / 65536);
        e.q[16*l +: 16]  = 16'((acc + 128) / 256);
      end
    end
    return e;
  endfunction

  // scoreboard: queue of accepted-but-undelivered beats, counter model mod 2^CNT_W
  exp_t exq[$];
  int   mcnt = 0;
  logic prev_stall = 0;
  logic [31:0] prev_pix;
  logic [63:0] prev_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      exq.delete();
      mcnt = 0;
      prev_stall = 0;
      chk("rst_cnt", 64'(contador_pixeles), 64'd0);
      chk("rst_valid", 64'(salida_valida), 64'd0);
    end else begin
      chk("listo", 64'(listo), 64'(entrada_lista));
      chk("ready", 64'(entrada_lista), 64'(!(salida_valida && !salida_lista)));
      chk("ocupado", 64'(ocupado), 64'(exq.size() != 0));
      chk("cnt", 64'(contador_pixeles), 64'(mcnt));
      if (prev_stall) begin
        chk("stall_pix", 64'(pixel_salida), 64'(prev_pix));
        chk("stall_q", pixel_salida_q, prev_q);
      end
      if (salida_valida) begin
        if (exq.size() == 0) chk("stray_beat", 64'(salida_valida), 64'd0);
        else begin
          chk("pix", 64'(pixel_salida), 64'(exq[0].pix));
          chk("pixq", pixel_salida_q, exq[0].q);
          chk("mask", 64'(mascara_salida), 64'(exq[0].m));
        end
      end
      prev_stall = salida_valida && !salida_lista;
      prev_pix = pixel_salida;
      prev_q = pixel_salida_q;
      if (salida_valida && salida_lista && exq.size() != 0) begin
        void'(exq.pop_front());
        delivered++;
        if (!limpiar_contador) mcnt = (mcnt + $countones(mascara_salida)) % 16;
      end
      if (limpiar_contador) mcnt = 0;
      if (entrada_valida && entrada_lista)
        exq.push_back(model(p00, p10, p01, p11, fx, fy, mascara_entrada));
    end
  end

  task automatic set_beat(input int idx, input logic [3:0] m);
    for (int l = 0; l < 4; l++) begin
      p00[8*l +: 8]  = 8'(idx * 37 + l * 11 + 5);
      p10[8*l +: 8]  = 8'(idx * 53 + l * 3 + 200);
      p01[8*l +: 8]  = 8'(idx * 19 + l * 71);
      p11[8*l +: 8]  = 8'(255 - idx * 13 - l);
      fx[16*l +: 16] = 16'(idx * 97 + l * 41 + (l << 8));
      fy[16*l +: 16] = 16'(idx * 61 + l * 23 + 'h300);
    end
    mascara_entrada = m;
  endtask

  // call at posedge+1 with an empty pipe; returns just after the edge that shows the beat
  task automatic single(input logic [31:0] a, b, c, d, input logic [63:0] x, y, input logic [3:0] m);
    p00 = a; p10 = b; p01 = c; p11 = d; fx = x; fy = y; mascara_entrada = m;
    entrada_valida = 1; salida_lista = 1;
    @(posedge clk); #1 entrada_valida = 0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  // pat 0: always ready; pat 1: ready on every third cycle; kind 1 forces full mask
  task automatic stream(input int n, input int pat, input int kind);
    int idx = 0, cyc = 0;
    logic acc;
    while ((idx < n || ocupado) && cyc < 400) begin
      if (idx < n) begin
        set_beat(idx, kind == 1 ? 4'hF : 4'(idx * 5 + 3));
        entrada_valida = 1;
      end else entrada_valida = 0;
      salida_lista = (pat == 0) || (cyc % 3 == 0);
      @(negedge clk); acc = entrada_valida && entrada_lista;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    entrada_valida = 0; salida_lista = 1;
    chk("stream_done", 64'(cyc < 400), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("r_valid", 64'(salida_valida), 0); chk("r_ready", 64'(entrada_lista), 1);
    chk("r_listo", 64'(listo), 1);         chk("r_ocup", 64'(ocupado), 0);
    chk("r_pix", 64'(pixel_salida), 0);    chk("r_q", pixel_salida_q, 0);
    chk("r_mask", 64'(mascara_salida), 0); chk("r_cnt", 64'(contador_pixeles), 0);

    // half weights: 255*32768 -> 128 / 0x7F80
    single(32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, {4{16'h0080}}, {4{16'h0080}}, 4'hF);
    chk("half_valid", 64'(salida_valida), 1);
    chk("half_pix", 64'(pixel_salida), 64'h80808080);
    chk("half_q", pixel_salida_q, 64'h7F807F807F807F80);
    @(posedge clk); #1 chk("half_cnt", 64'(contador_pixeles), 4);
    chk("half_drained", 64'(salida_valida), 0);

    // corners and integer-part ignore
    single({8'd0, 8'd0, 8'd255, 8'd37}, {8'd255, 8'd255, 8'd255, 8'd99},
           {8'd0, 8'd0, 8'd255, 8'd99}, {8'd255, 8'd255, 8'd255, 8'd99},
           {16'h0080, 16'h0180, 16'h00FF, 16'h0000}, {16'h0080, 16'h0080, 16'h00FF, 16'h0000}, 4'hF);
    chk("corner_pix", 64'(pixel_salida), 64'h8080FF25);
    chk("corner_q", pixel_salida_q, 64'h7F807F80FF002500);
    @(posedge clk); #1 chk("corner_cnt", 64'(contador_pixeles), 8);

    // mask 0101
    single(32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, {4{16'h0080}}, {4{16'h0080}}, 4'b0101);
    chk("mask_pix", 64'(pixel_salida), 64'h00800080);
    chk("mask_q", pixel_salida_q, 64'h00007F8000007F80);
    chk("mask_out", 64'(mascara_salida), 64'b0101);
    @(posedge clk); #1 chk("mask_cnt", 64'(contador_pixeles), 10);

    // backpressure stream of 10 beats
    delivered = 0;
    stream(10, 1, 0);
    chk("bp_delivered", 64'(delivered), 10);

    // clear, then wrap: 5 x 4 lanes = 20 mod 16
    limpiar_contador = 1;
    @(posedge clk); #1 limpiar_contador = 0;
    chk("clr_cnt", 64'(contador_pixeles), 0);
    stream(5, 0, 1);
    chk("wrap_cnt", 64'(contador_pixeles), 4);

    // clear on the handshake edge wins
    single(32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, {4{16'h0080}}, {4{16'h0080}}, 4'hF);
    limpiar_contador = 1;
    @(posedge clk); #1 limpiar_contador = 0;
    chk("clr_hs_cnt", 64'(contador_pixeles), 0);
    chk("clr_hs_drained", 64'(salida_valida), 0);

    // reset with 3 beats in flight
    for (int j = 0; j < 3; j++) begin
      set_beat(j + 20, 4'hF);
      entrada_valida = 1;
      @(posedge clk); #1;
    end
    entrada_valida = 0;
    chk("pre_rst_valid", 64'(salida_valida), 1);
    rst_n = 0;
    #1;
    chk("mr_valid", 64'(salida_valida), 0); chk("mr_ready", 64'(entrada_lista), 1);
    chk("mr_pix", 64'(pixel_salida), 0);    chk("mr_q", pixel_salida_q, 0);
    chk("mr_mask", 64'(mascara_salida), 0); chk("mr_cnt", 64'(contador_pixeles), 0);
    chk("mr_ocup", 64'(ocupado), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (6) @(posedge clk);
    #1 chk("post_rst_idle", 64'(ocupado), 0);
    chk("post_rst_cnt", 64'(contador_pixeles), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
